// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters, returning result/branch compare and tag to the winner.
// Latency: accept edge, one EXEC edge to capture the result, then rsp_valid holds until consumed (>= 3 cycles per op).
// Backpressure: a single op is in flight; req_ready stays low until the owner takes its response or flush aborts it.
module alu_share_arbiter #(
    parameter int TAG_W = 4,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             r0_req_valid,
    output logic             r0_req_ready,
    input  logic [31:0]      r0_a,
    input  logic [31:0]      r0_b,
    input  logic [6:0]       r0_aluop,
    input  logic [2:0]       r0_funct3,
    input  logic [6:0]       r0_funct7,
    input  logic [TAG_W-1:0] r0_tag,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [31:0]      r0_rsp_result,
    output logic             r0_rsp_bcmp,
    output logic [TAG_W-1:0] r0_rsp_tag,
    input  logic             r1_req_valid,
    output logic             r1_req_ready,
    input  logic [31:0]      r1_a,
    input  logic [31:0]      r1_b,
    input  logic [6:0]       r1_aluop,
    input  logic [2:0]       r1_funct3,
    input  logic [6:0]       r1_funct7,
    input  logic [TAG_W-1:0] r1_tag,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [31:0]      r1_rsp_result,
    output logic             r1_rsp_bcmp,
    output logic [TAG_W-1:0] r1_rsp_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [6:0]       alu_aluop,
    output logic [2:0]       alu_funct3,
    output logic [6:0]       alu_funct7,
    input  logic [31:0]      alu_result,
    input  logic             alu_branch_cmp,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q;
    logic                    rr_ptr_q;
    logic [TAG_W-1:0]        tag_q;
    logic [1:0]              rsp_vld_q;
    logic [1:0]              rsp_bcmp_q;
    logic [1:0][31:0]        rsp_result_q;
    logic [1:0][TAG_W-1:0]   rsp_tag_q;

    logic winner;
    logic accept;
    logic owner_rsp_rdy;

    // Only r1 valid -> r1; only r0 valid -> r0; both -> pointer (RR) or r0 (fixed).
    assign winner        = (r0_req_valid && r1_req_valid) ? (RR_EN ? rr_ptr_q : 1'b0) : !r0_req_valid;
    assign accept        = (state_q == IDLE) && !flush && (r0_req_valid || r1_req_valid);
    assign r0_req_ready  = accept && !winner;
    assign r1_req_ready  = accept && winner;
    assign owner_rsp_rdy = owner_q ? r1_rsp_ready : r0_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = EXEC;
                EXEC:    state_d = RESP;
                RESP:    if (owner_rsp_rdy) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            rr_ptr_q     <= 1'b0;
            tag_q        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_aluop    <= '0;
            alu_funct3   <= '0;
            alu_funct7   <= '0;
            rsp_vld_q    <= '0;
            rsp_bcmp_q   <= '0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
        end else begin
            if (accept) begin
                alu_a      <= winner ? r1_a      : r0_a;
                alu_b      <= winner ? r1_b      : r0_b;
                alu_aluop  <= winner ? r1_aluop  : r0_aluop;
                alu_funct3 <= winner ? r1_funct3 : r0_funct3;
                alu_funct7 <= winner ? r1_funct7 : r0_funct7;
                tag_q      <= winner ? r1_tag    : r0_tag;
                owner_q    <= winner;
                rr_ptr_q   <= !winner;
            end
            // Flush wins over both the capture and the response handshake.
            if (flush) begin
                rsp_vld_q <= '0;
            end else if (state_q == EXEC) begin
                rsp_result_q[owner_q] <= alu_result;
                rsp_bcmp_q[owner_q]   <= alu_branch_cmp;
                rsp_tag_q[owner_q]    <= tag_q;
                rsp_vld_q[owner_q]    <= 1'b1;
            end else if (state_q == RESP && owner_rsp_rdy) begin
                rsp_vld_q <= '0;
            end
        end
    end

    assign r0_rsp_valid  = rsp_vld_q[0];
    assign r1_rsp_valid  = rsp_vld_q[1];
    assign r0_rsp_result = rsp_result_q[0];
    assign r1_rsp_result = rsp_result_q[1];
    assign r0_rsp_bcmp   = rsp_bcmp_q[0];
    assign r1_rsp_bcmp   = rsp_bcmp_q[1];
    assign r0_rsp_tag    = rsp_tag_q[0];
    assign r1_rsp_tag    = rsp_tag_q[1];
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter with a scoreboard of expected responses.
module tb_alu_share_arbiter;
    localparam int TAG_W = 4;
    localparam bit RR_EN = 1'b1;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [6:0]       op;
        logic [2:0]       f3;
        logic [6:0]       f7;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct {
        bit               own;
        logic [31:0]      res;
        logic             bcmp;
        logic [TAG_W-1:0] tag;
        int               acyc;
        bit               seen;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
    logic v0 = 1'b0, v1 = 1'b0, rr0 = 1'b1, rr1 = 1'b1;
    req_t p0 = '0, p1 = '0;
    logic r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_bcmp, r1_rsp_bcmp, busy;
    logic [31:0] r0_rsp_result, r1_rsp_result, alu_a, alu_b, alu_result;
    logic [TAG_W-1:0] r0_rsp_tag, r1_rsp_tag;
    logic [6:0] alu_aluop, alu_funct7;
    logic [2:0] alu_funct3;
    logic alu_branch_cmp;

    int n_vec = 0, n_err = 0, cyc = 0, acc_cnt = 0, done_cnt = 0;
    bit m_ptr = 1'b0;
    exp_t sbq[$];
    bit grants[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter #(.TAG_W(TAG_W), .RR_EN(RR_EN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .r0_req_valid(v0), .r0_req_ready(r0_req_ready), .r0_a(p0.a), .r0_b(p0.b),
        .r0_aluop(p0.op), .r0_funct3(p0.f3), .r0_funct7(p0.f7), .r0_tag(p0.tag),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(rr0), .r0_rsp_result(r0_rsp_result),
        .r0_rsp_bcmp(r0_rsp_bcmp), .r0_rsp_tag(r0_rsp_tag),
        .r1_req_valid(v1), .r1_req_ready(r1_req_ready), .r1_a(p1.a), .r1_b(p1.b),
        .r1_aluop(p1.op), .r1_funct3(p1.f3), .r1_funct7(p1.f7), .r1_tag(p1.tag),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(rr1), .r1_rsp_result(r1_rsp_result),
        .r1_rsp_bcmp(r1_rsp_bcmp), .r1_rsp_tag(r1_rsp_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluop(alu_aluop), .alu_funct3(alu_funct3),
        .alu_funct7(alu_funct7), .alu_result(alu_result), .alu_branch_cmp(alu_branch_cmp),
        .busy(busy)
    );

    // Small RV-style ALU: {branch_cmp, result}
    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [31:0] r;
        logic        c;
        case (f3)
            3'b000:  r = (op == 7'b0110011 && f7 == 7'h20) ? a - b : a + b;
            3'b111:  r = a & b;
            3'b110:  r = a | b;
            3'b100:  r = a ^ b;
            default: r = a + b;
        endcase
        c = 1'b0;
        if (op == 7'b1100011) begin
            case (f3)
                3'b000:  c = (a == b);
                3'b001:  c = (a != b);
                3'b100:  c = ($signed(a) < $signed(b));
                3'b101:  c = ($signed(a) >= $signed(b));
                default: c = 1'b0;
            endcase
        end
        return {c, r};
    endfunction

    always_comb {alu_branch_cmp, alu_result} = ref_alu(alu_a, alu_b, alu_aluop, alu_funct3, alu_funct7);

    function automatic req_t rand_req();
        req_t q;
        logic [2:0] f3s [4];
        f3s[0] = 3'b000; f3s[1] = 3'b111; f3s[2] = 3'b110; f3s[3] = 3'b100;
        q.a   = $urandom;
        q.b   = ($urandom_range(0, 3) == 0) ? q.a : $urandom;
        q.tag = TAG_W'($urandom);
        if ($urandom_range(0, 2) == 0) begin
            q.op = 7'b1100011;
            q.f3 = 3'($urandom_range(0, 1) + 4 * $urandom_range(0, 1));
            q.f7 = 7'h00;
        end else begin
            q.op = 7'b0110011;
            q.f3 = f3s[$urandom_range(0, 3)];
            q.f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return q;
    endfunction

    // Issue side: predicts the grant from the arbitration rules and records the expected response.
    always @(negedge clk) begin : issue
        bit   idle, any, win, e0, e1;
        req_t w;
        exp_t e;
        if (!rst_n) begin
            m_ptr <= 1'b0;
        end else begin
            idle = (acc_cnt == done_cnt);
            any  = v0 || v1;
            win  = (v0 && v1) ? (RR_EN ? m_ptr : 1'b0) : v1;
            e0   = idle && !flush && any && !win;
            e1   = idle && !flush && any && win;
            n_vec++;
            if ({r0_req_ready, r1_req_ready} !== {e0, e1}) begin
                n_err++;
                $display("FAIL req_ready cyc=%0d got r0/r1=%b%b want %b%b", cyc, r0_req_ready, r1_req_ready, e0, e1);
            end
            if (e0 || e1) begin
                w = win ? p1 : p0;
                {e.bcmp, e.res} = ref_alu(w.a, w.b, w.op, w.f3, w.f7);
                e.own  = win;
                e.tag  = w.tag;
                e.acyc = cyc;
                e.seen = 1'b0;
                sbq.push_back(e);
                grants.push_back(win);
                acc_cnt <= acc_cnt + 1;
                m_ptr   <= !win;
            end
        end
    end

    // Response monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [31:0]      gres;
        logic             gbcmp;
        logic [TAG_W-1:0] gtag;
        if (!rst_n) begin
            sbq.delete();
            done_cnt <= acc_cnt;
        end else begin
            if (r0_rsp_valid || r1_rsp_valid) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected cyc=%0d got valid r0/r1=%b%b want none", cyc, r0_rsp_valid, r1_rsp_valid);
                end else begin
                    e     = sbq[0];
                    gres  = e.own ? r1_rsp_result : r0_rsp_result;
                    gbcmp = e.own ? r1_rsp_bcmp   : r0_rsp_bcmp;
                    gtag  = e.own ? r1_rsp_tag    : r0_rsp_tag;
                    if ({r1_rsp_valid, r0_rsp_valid} !== {e.own, !e.own} || gres !== e.res ||
                        gbcmp !== e.bcmp || gtag !== e.tag) begin
                        n_err++;
                        $display("FAIL rsp_data cyc=%0d got vld=%b%b res=%h bcmp=%b tag=%h want owner=%0d res=%h bcmp=%b tag=%h",
                                 cyc, r1_rsp_valid, r0_rsp_valid, gres, gbcmp, gtag, e.own, e.res, e.bcmp, e.tag);
                    end
                    if (!e.seen) begin
                        n_vec++;
                        if (cyc - e.acyc != 2) begin
                            n_err++;
                            $display("FAIL rsp_latency got %0d cycles want 2", cyc - e.acyc);
                        end
                        sbq[0].seen = 1'b1;
                    end
                    if (!flush && (e.own ? rr1 : rr0)) begin
                        void'(sbq.pop_front());
                        done_cnt <= done_cnt + 1;
                    end
                end
            end else if (sbq.size() > 0 && (sbq[0].seen || cyc - sbq[0].acyc > 4)) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_missing cyc=%0d got rsp_valid=0 want response tag=%h", cyc, sbq[0].tag);
                void'(sbq.pop_front());
                done_cnt <= done_cnt + 1;
            end
            if (flush) begin
                sbq.delete();
                done_cnt <= acc_cnt;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input bit n);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (n ? r1_req_ready : r0_req_ready) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout r%0d got no req_ready want accept", n);
        end
        tick();
        if (n) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy && sbq.size() == 0 && !r0_rsp_valid && !r1_rsp_valid) done = 1'b1;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout got busy=%b pending=%0d want idle", busy, sbq.size());
        end
        tick();
    endtask

    // Issue one op, then check the response one cycle after the EXEC edge against fixed values.
    task automatic run_check(input bit n, input req_t q, input bit chk_res, input logic [31:0] xres,
                             input logic xbcmp, input string name);
        if (n) begin p1 = q; v1 = 1'b1; end else begin p0 = q; v0 = 1'b1; end
        wait_accept(n);
        tick();
        @(negedge clk);
        n_vec++;
        if ((n ? r1_rsp_valid : r0_rsp_valid) !== 1'b1 ||
            (chk_res && (n ? r1_rsp_result : r0_rsp_result) !== xres) ||
            (n ? r1_rsp_bcmp : r0_rsp_bcmp) !== xbcmp || (n ? r1_rsp_tag : r0_rsp_tag) !== q.tag) begin
            n_err++;
            $display("FAIL %s got vld=%b res=%h bcmp=%b tag=%h want vld=1 res=%h bcmp=%b tag=%h", name,
                     n ? r1_rsp_valid : r0_rsp_valid, n ? r1_rsp_result : r0_rsp_result,
                     n ? r1_rsp_bcmp : r0_rsp_bcmp, n ? r1_rsp_tag : r0_rsp_tag, xres, xbcmp, q.tag);
        end
        wait_idle();
    endtask

    task automatic chk_zero(input string name);
        n_vec++;
        if ({busy, r0_rsp_valid, r1_rsp_valid, r0_rsp_result, r1_rsp_result, r0_rsp_tag, r1_rsp_tag,
             r0_rsp_bcmp, r1_rsp_bcmp, alu_a, alu_b, alu_aluop, alu_funct3, alu_funct7} !== '0) begin
            n_err++;
            $display("FAIL %s got busy=%b vld=%b%b res0=%h res1=%h alu_a=%h alu_b=%h op=%h want all 0",
                     name, busy, r0_rsp_valid, r1_rsp_valid, r0_rsp_result, r1_rsp_result, alu_a, alu_b, alu_aluop);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        req_t q;
        int   c0, c1, gs;
        logic [TAG_W-1:0] htag;
        logic [31:0]      hres;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk_zero("reset_state");
        rst_n = 1'b1;
        tick();

        q = '{a: 32'd5, b: 32'd7, op: 7'b0110011, f3: 3'b000, f7: 7'h00, tag: 4'd3};
        run_check(1'b0, q, 1'b1, 32'd12, 1'b0, "single_add");

        q = '{a: 32'h1234, b: 32'h1234, op: 7'b1100011, f3: 3'b000, f7: 7'h00, tag: 4'd9};
        run_check(1'b1, q, 1'b0, 32'd0, 1'b1, "beq_equal");
        q = '{a: 32'd1, b: 32'd2, op: 7'b1100011, f3: 3'b000, f7: 7'h00, tag: 4'd10};
        run_check(1'b1, q, 1'b0, 32'd0, 1'b0, "beq_differ");

        // Contention: pointer now points at r0, so grants alternate starting with r0.
        gs = grants.size();
        c0 = 0; c1 = 0;
        p0 = rand_req(); p1 = rand_req(); v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 120 && (c0 < 4 || c1 < 4); i++) begin
            @(negedge clk);
            if (r0_req_ready) c0++;
            if (r1_req_ready) c1++;
            tick();
            v0 = (c0 < 4); v1 = (c1 < 4);
            p0 = rand_req(); p1 = rand_req();
        end
        v0 = 1'b0; v1 = 1'b0;
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (grants.size() <= gs + i || grants[gs + i] != bit'(i % 2)) begin
                n_err++;
                $display("FAIL rr_grant[%0d] got %0d want %0d", i, grants.size() > gs + i ? int'(grants[gs + i]) : -1, i % 2);
            end
        end

        // Response backpressure on r1 while r0 keeps requesting.
        rr1 = 1'b0;
        p1 = rand_req(); v1 = 1'b1;
        wait_accept(1'b1);
        p0 = rand_req(); v0 = 1'b1;
        tick();
        htag = r1_rsp_tag; hres = r1_rsp_result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b1 || r1_rsp_tag !== htag || r1_rsp_result !== hres) begin
                n_err++;
                $display("FAIL bp_hold got busy=%b tag=%h res=%h want busy=1 tag=%h res=%h", busy, r1_rsp_tag, r1_rsp_result, htag, hres);
            end
            tick();
        end
        rr1 = 1'b1;
        wait_accept(1'b0);
        wait_idle();

        // Flush while in EXEC.
        p0 = rand_req(); v0 = 1'b1;
        wait_accept(1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if ({busy, r0_rsp_valid, r1_rsp_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL flush_exec got busy/vld=%b%b%b want 000", busy, r0_rsp_valid, r1_rsp_valid);
        end
        run_check(1'b1, '{a: 32'd100, b: 32'd58, op: 7'b0110011, f3: 3'b000, f7: 7'h20, tag: 4'd6},
                  1'b1, 32'd42, 1'b0, "after_flush_exec");

        // Flush in RESP colliding with the response handshake.
        p0 = rand_req(); v0 = 1'b1;
        wait_accept(1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_vec++;
        if ({busy, r0_rsp_valid, r1_rsp_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL flush_resp got busy/vld=%b%b%b want 000", busy, r0_rsp_valid, r1_rsp_valid);
        end
        run_check(1'b0, '{a: 32'hF0F0, b: 32'h0FF0, op: 7'b0110011, f3: 3'b111, f7: 7'h00, tag: 4'd12},
                  1'b1, 32'h00F0, 1'b0, "after_flush_resp");

        // Async reset in RESP; first contended grant afterwards goes to r0.
        rr0 = 1'b0;
        p1 = rand_req(); v1 = 1'b1;
        wait_accept(1'b1);
        tick();
        #2 rst_n = 1'b0;
        #1 chk_zero("reset_in_resp");
        tick();
        rst_n = 1'b1;
        rr0 = 1'b1;
        p0 = rand_req(); p1 = rand_req(); v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({r0_req_ready, r1_req_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL ptr_after_reset got r0/r1=%b%b want 10", r0_req_ready, r1_req_ready);
        end
        wait_accept(1'b0);
        wait_accept(1'b1);
        wait_idle();

        // Random traffic with response backpressure and occasional flush.
        for (int i = 0; i < 500; i++) begin
            v0 = ($urandom_range(0, 1) == 1);
            v1 = ($urandom_range(0, 1) == 1);
            p0 = rand_req(); p1 = rand_req();
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        v0 = 1'b0; v1 = 1'b0; flush = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
